// File: rtl/falconsoar_pkg.sv
// Shared buffer constants, address type and bank-select helper for the buffer responder.
package falconsoar_pkg;
  localparam int BANK_NUM   = 4;
  localparam int BANK_DEPTH = 256;
  localparam int BUFF_DW    = 256;
  localparam int BUFF_AW    = $clog2(BANK_NUM * BANK_DEPTH);
  localparam int BANK_SEL_W = $clog2(BANK_NUM);

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef logic [BUFF_AW-1:0]    mem_addr_t;
  typedef logic [BANK_SEL_W-1:0] bank_sel_t;

  function automatic bank_sel_t bank_sel_f(mem_addr_t addr);
    return addr[BUFF_AW-1 -: BANK_SEL_W];
  endfunction
endpackage

// File: rtl/buff_bank_if.sv
// Read/write port bundle between execution units (master) and the buffer responder (slave).
interface buff_bank_if #(
  parameter int NP = 4,
  parameter int AW = 10,
  parameter int DW = 256
);
  logic [NP-1:0]    rd_en;
  logic [NP*AW-1:0] rd_addr;
  logic [NP*DW-1:0] rd_data;
  logic [NP-1:0]    rd_vld;
  logic [NP-1:0]    wr_en;
  logic [NP*AW-1:0] wr_addr;
  logic [NP*DW-1:0] wr_data;

  modport master (output rd_en, rd_addr, wr_en, wr_addr, wr_data,
                  input  rd_data, rd_vld);
  modport slave  (input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
                  output rd_data, rd_vld);
endinterface

// File: rtl/buff_bank_ram.sv
// Single 1R1W buffer bank with registered read; read-first on same-row collisions.
module buff_bank_ram #(
  parameter int DEPTH = 256,
  parameter int DW    = 256
) (
  input  logic                     clk,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DW-1:0]            rdata,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DW-1:0]            wdata
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/buff_bank_responder.sv
// Banked buffer responder: per-bank fixed-priority arbitration, RD_LAT read pipeline, conflict debug.
// Optional BUFF_WR_FWD_EN: same-cycle write to the read row is bypassed into the read result.
module buff_bank_responder #(
  parameter int NP         = 4,
  parameter int NB         = falconsoar_pkg::BANK_NUM,
  parameter int BANK_DEPTH = falconsoar_pkg::BANK_DEPTH,
  parameter int AW         = falconsoar_pkg::BUFF_AW,
  parameter int DW         = falconsoar_pkg::BUFF_DW,
  parameter int RD_LAT     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  buff_bank_if.slave  bus,
  input  logic        conflict_clr,
  output logic        rd_conflict,
  output logic        wr_conflict,
  output logic [15:0] conflict_cnt
);
  import falconsoar_pkg::*;

  localparam int BW = $clog2(NB);
  localparam int RW = $clog2(BANK_DEPTH);

  logic [NP-1:0][BW-1:0] rd_bank, wr_bank;
  logic [NP-1:0][RW-1:0] rd_row, wr_row;
  logic [NP-1:0]         rd_win, wr_win;

  logic [NB-1:0]         bank_re, bank_we;
  logic [NB-1:0][RW-1:0] bank_rrow, bank_wrow;
  logic [NB-1:0][DW-1:0] bank_wdata, bank_rdata, bank_out;

  logic [RD_LAT:1][NP-1:0] vld_pipe;
  logic [NP-1:0]           win_q;
  logic [NP-1:0][BW-1:0]   bank_q;
  logic [NP-1:0][DW-1:0]   steer;

  logic rd_hit, wr_hit;

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      rd_bank[p] = bus.rd_addr[p*AW+AW-1 -: BW];
      rd_row[p]  = bus.rd_addr[p*AW +: RW];
      wr_bank[p] = bus.wr_addr[p*AW+AW-1 -: BW];
      wr_row[p]  = bus.wr_addr[p*AW +: RW];
    end
  end

  // Fixed priority: a port wins its bank unless a lower-index port targets the same bank.
  always_comb begin
    rd_win = bus.rd_en;
    wr_win = bus.wr_en;
    for (int p = 1; p < NP; p++) begin
      for (int q = 0; q < p; q++) begin
        if (bus.rd_en[q] && rd_bank[q] == rd_bank[p]) rd_win[p] = 1'b0;
        if (bus.wr_en[q] && wr_bank[q] == wr_bank[p]) wr_win[p] = 1'b0;
      end
    end
  end

  assign rd_hit = |(bus.rd_en & ~rd_win);
  assign wr_hit = |(bus.wr_en & ~wr_win);

  // Writes seen while reset is asserted never reach the banks.
  always_comb begin
    bank_re    = '0;
    bank_rrow  = '0;
    bank_we    = '0;
    bank_wrow  = '0;
    bank_wdata = '0;
    for (int p = 0; p < NP; p++) begin
      if (rd_win[p]) begin
        bank_re[rd_bank[p]]   = 1'b1;
        bank_rrow[rd_bank[p]] = rd_row[p];
      end
      if (wr_win[p] && !rst_n) begin
        bank_we[wr_bank[p]]    = 1'b1;
        bank_wrow[wr_bank[p]]  = wr_row[p];
        bank_wdata[wr_bank[p]] = bus.wr_data[p*DW +: DW];
      end
    end
  end

  for (genvar b = 0; b < NB; b++) begin : g_bank
    buff_bank_ram #(.DEPTH(BANK_DEPTH), .DW(DW)) u_ram (
      .clk   (clk),
      .re    (bank_re[b]),
      .raddr (bank_rrow[b]),
      .rdata (bank_rdata[b]),
      .we    (bank_we[b]),
      .waddr (bank_wrow[b]),
      .wdata (bank_wdata[b])
    );
  end

`ifdef BUFF_WR_FWD_EN
  logic [NB-1:0]         fwd_q;
  logic [NB-1:0][DW-1:0] fwd_dat_q;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) fwd_q <= '0;
    else
      for (int b = 0; b < NB; b++)
        fwd_q[b] <= bank_re[b] && bank_we[b] && (bank_rrow[b] == bank_wrow[b]);
  end

  always_ff @(posedge clk) fwd_dat_q <= bank_wdata;

  for (genvar b = 0; b < NB; b++) begin : g_fwd
    assign bank_out[b] = fwd_q[b] ? fwd_dat_q[b] : bank_rdata[b];
  end
`else
  assign bank_out = bank_rdata;
`endif

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      vld_pipe <= '0;
      win_q    <= '0;
      bank_q   <= '0;
    end else begin
      vld_pipe[1] <= bus.rd_en;
      for (int s = 2; s <= RD_LAT; s++) vld_pipe[s] <= vld_pipe[s-1];
      win_q  <= rd_win;
      bank_q <= rd_bank;
    end
  end

  // Losing and idle ports get zero data; the RAM output is only trusted for winners.
  always_comb begin
    for (int p = 0; p < NP; p++)
      steer[p] = win_q[p] ? bank_out[bank_q[p]] : '0;
  end

  if (RD_LAT == 1) begin : g_lat1
    assign bus.rd_data = steer;
  end else begin : g_latn
    logic [RD_LAT-1:1][NP*DW-1:0] dat_q;

    always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) dat_q <= '0;
      else begin
        dat_q[1] <= steer;
        for (int s = 2; s < RD_LAT; s++) dat_q[s] <= dat_q[s-1];
      end
    end

    assign bus.rd_data = dat_q[RD_LAT-1];
  end

  assign bus.rd_vld = vld_pipe[RD_LAT];

  // A conflict in the clearing cycle wins over the clear.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rd_conflict  <= 1'b0;
      wr_conflict  <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      rd_conflict <= rd_hit | (rd_conflict & ~conflict_clr);
      wr_conflict <= wr_hit | (wr_conflict & ~conflict_clr);
      if (conflict_clr)
        conflict_cnt <= {15'd0, rd_hit | wr_hit};
      else if ((rd_hit | wr_hit) && conflict_cnt != CNT_MAX)
        conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
endmodule

// File: doc/buff_bank_responder.md
Name: buff_bank_responder

Overview:
- Responder end of the buffer read/write port protocol: serves NP read ports and NP write ports issued by execution units (format transfer, FFT, FPU tasks).
- Storage is NB independent 1R1W banks.
- The bank is selected by the upper address bits and the row by the lower bits.
- Per-bank arbitration, fixed-latency read pipeline, conflict detection and a saturating conflict counter for debug.

Parameters:
- NP, 4, number of read ports and number of write ports.
- NB, 4, number of banks (power of two).
- BANK_DEPTH, 256, rows per bank (power of two).
- AW, 10, address width = log2(NB*BANK_DEPTH).
- DW, 256, data width per port (4 x 64-bit floats).
- RD_LAT, 2, read latency in cycles, legal range 1..4.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-high (asserted = 1), as already decided
- rd_en  in  NP  per-port read request
- rd_addr  in  NP*AW  per-port read address, port i at [i*AW +: AW]
- rd_data  out  NP*DW  per-port read data
- rd_vld  out  NP  read data valid, aligned with rd_data
- wr_en  in  NP  per-port write request
- wr_addr  in  NP*AW  per-port write address
- wr_data  in  NP*DW  per-port write data
- conflict_clr  in  1  synchronous clear of conflict status
- rd_conflict  out  1  sticky: two or more reads hit one bank in the same cycle
- wr_conflict  out  1  sticky: two or more writes hit one bank in the same cycle
- conflict_cnt  out  16  saturating count of cycles with any conflict

Behaviour:
- Address decode: bank = addr[AW-1 -: log2(NB)]; row = addr[log2(BANK_DEPTH)-1:0].
- Read arbitration per bank, each cycle: the lowest-index requesting port wins. Losing ports still get rd_vld after RD_LAT cycles, with rd_data forced to 0.
- Write arbitration per bank, each cycle: the lowest-index requesting port wins. Losing writes are dropped and the bank is not modified.
- Read latency: rd_en at cycle t -> rd_vld/rd_data at t+RD_LAT. Fully pipelined: one read per port per cycle, no backpressure.
- Read and write to the same bank and row in the same cycle: read-first, returning the old data (unless the optional feature below is enabled).
- Writes take effect at the clock edge. A read issued at t+1 sees a write committed at t.
- rd_conflict / wr_conflict:
  - Set in the cycle after the conflicting request.
  - Held until conflict_clr.
  - If conflict_clr and a new conflict occur in the same cycle, the new conflict wins (flag stays set).
- conflict_cnt:
  - +1 per cycle with any rd or wr conflict.
  - Saturates at 16'hFFFF.
  - conflict_clr zeroes it; a conflict in the same cycle gives a value of 1.
- Reset values: rd_vld=0, rd_data=0, rd_conflict=0, wr_conflict=0, conflict_cnt=0.
- Bank contents are not reset.
- Reset mid-operation: in-flight reads are discarded and no rd_vld is produced for them. Writes coincident with reset assertion are dropped.
- Idle ports (rd_en=0): rd_vld=0 and rd_data holds 0 at the corresponding output cycle.

Optional Feature:
- Macro: BUFF_WR_FWD_EN.
- Defined: same-cycle read/write to the same bank and row returns the winning write's wr_data (write-first bypass), routed through the read pipeline with the same RD_LAT.
- Undefined: read-first behaviour as above; no bypass muxing is generated.

Decomposition:
- falconsoar_pkg gains:
  - BANK_NUM and BANK_DEPTH constants, and the BUFF_DW constant.
  - mem_addr_t (reuse).
  - A bank_sel_f function that extracts the bank index from an address.
- Sub-module buff_bank_ram: a single bank, 1R1W, registered read, parameters DEPTH and DW, instantiated NB times.
- The top level holds the arbiters, the read-valid/port-steering pipeline, the conflict logic and the optional bypass.

Test Plan:
- Write port0 addr 0x005 data 0xA5..A5, then read port1 addr 0x005 one cycle later -> rd_vld[1]=1 exactly RD_LAT=2 cycles after rd_en, rd_data[1]=0xA5..A5.
- Reads in the same cycle: port0 addr 0x010 (bank0) and port2 addr 0x110 (bank1) -> both return stored data, rd_conflict stays 0.
- Reads in the same cycle: port1 addr 0x020 and port3 addr 0x030 (both bank0) -> port1 returns stored data, port3 returns 0 with rd_vld=1, rd_conflict=1, conflict_cnt=1.
- Writes in the same cycle: port0 (0x300, 0x11..) and port1 (0x301, 0x22..), both bank3 -> read 0x300=0x11.., 0x301 unchanged, wr_conflict=1. Apply conflict_clr -> flags and count return to 0.
- Same-cycle read and write to 0x040, old=0x1, new=0x2 -> read returns 0x1 without BUFF_WR_FWD_EN, 0x2 with it.
- Assert rst_n=1 one cycle after rd_en -> no rd_vld emerges and all outputs are 0. Force 70000 conflict cycles -> conflict_cnt=16'hFFFF.
